// File: rtl/dpp_pkg.sv
// Shared types and helpers for the DPP chain: peak word type, histogram FSM
// state encoding and the saturating increment used by all counters.
package dpp_pkg;

  localparam int WD = 23;

  typedef logic signed [WD:0] peak_t;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_READ   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Increment holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] top;
    top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= top) ? top : value + 64'd1;
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port synchronous RAM: port A read/write (read-first), port B read-only.
module hist_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  // Port B returns the pre-write contents when colliding with a port-A write.
  always_ff @(posedge clk) begin
    if (rst)       b_rdata <= '0;
    else if (b_re) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/peak_histogram.sv
// Pulse-height histogram: pulls peaks from the detector, bins them into a RAM
// with a CLEAR/IDLE/READ/UPDATE sequencer, and exposes a host read port.
module peak_histogram
  import dpp_pkg::*;
#(
  parameter int BIN_BITS  = 10,
  parameter int BIN_SHIFT = 13,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  peak_t               peak_in,
  input  logic                valid_in,
  output logic                read_shift,
  input  logic                acq_en,
  input  logic                clear_req,
  output logic                busy,
  input  logic [BIN_BITS-1:0] host_addr,
  input  logic                host_rd,
  output logic [CNT_W-1:0]    host_data,
  output logic                host_valid,
  output logic [CNT_W-1:0]    event_count,
  output logic [CNT_W-1:0]    under_count,
  output logic [CNT_W-1:0]    over_count,
  output state_t              dbg_state
);

  localparam int    NBINS   = 2**BIN_BITS;
  localparam peak_t MAX_BIN = peak_t'(NBINS - 1);

  state_t              state;
  logic [BIN_BITS-1:0] clr_addr;
  logic [BIN_BITS-1:0] bin_q;
  logic                clr_pend;

  peak_t               shifted;
  logic                clamp;
  logic [BIN_BITS-1:0] bin_next;

  logic                we;
  logic [BIN_BITS-1:0] a_addr;
  logic [CNT_W-1:0]    wdata;
  logic [CNT_W-1:0]    rdata;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic [63:0] w;
    w = sat_inc(64'(v), CNT_W);
    return w[CNT_W-1:0];
  endfunction

  always_comb begin
    shifted  = peak_in >>> BIN_SHIFT;
    clamp    = shifted > MAX_BIN;
    bin_next = clamp ? '1 : shifted[BIN_BITS-1:0];
  end

  // Reset suppresses the write so an in-flight update is abandoned cleanly.
  always_comb begin
    we     = !rst && (state == ST_CLEAR || state == ST_UPDATE);
    a_addr = (state == ST_CLEAR) ? clr_addr : bin_q;
    wdata  = (state == ST_CLEAR) ? '0 : inc(rdata);
  end

  assign read_shift = (state == ST_IDLE);
  assign busy       = (state == ST_CLEAR);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      clr_addr    <= '0;
      bin_q       <= '0;
      clr_pend    <= 1'b0;
      event_count <= '0;
      under_count <= '0;
      over_count  <= '0;
      host_valid  <= 1'b0;
    end else begin
      host_valid <= host_rd;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          clr_pend <= 1'b0;
          if (clr_addr == '1) begin
            state       <= ST_IDLE;
            event_count <= '0;
            under_count <= '0;
            over_count  <= '0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end else if (valid_in && acq_en) begin
            if (peak_in[WD]) begin
              under_count <= inc(under_count);
            end else begin
              bin_q <= bin_next;
              if (clamp) over_count <= inc(over_count);
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (clear_req) clr_pend <= 1'b1;
          state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          event_count <= inc(event_count);
          if (clear_req || clr_pend) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            clr_pend <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  hist_ram #(
    .AW (BIN_BITS),
    .DW (CNT_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_we    (we),
    .a_addr  (a_addr),
    .a_wdata (wdata),
    .a_rdata (rdata),
    .b_re    (host_rd),
    .b_addr  (host_addr),
    .b_rdata (host_data)
  );

endmodule

// File: tb/tb_peak_histogram.sv
// Bench for peak_histogram: three builds (default, BIN_SHIFT=10, CNT_W=4) share
// one stimulus stream; host reads are scored against a spec-level bin model.
module tb_peak_histogram;
  import dpp_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  peak_t      peak_in;
  logic       valid_in, acq_en, clear_req, host_rd;
  logic [9:0] host_addr;

  logic        m_rs, m_busy, m_hv;
  logic [31:0] m_hd, m_ev, m_un, m_ov;
  state_t      m_st;
  logic        o_rs, o_busy, o_hv;
  logic [31:0] o_hd, o_ev, o_un, o_ov;
  state_t      o_st;
  logic        s_rs, s_busy, s_hv;
  logic [3:0]  s_hd, s_ev, s_un, s_ov;
  state_t      s_st;

  peak_histogram u_main (
    .clk(clk), .rst(rst), .peak_in(peak_in), .valid_in(valid_in), .read_shift(m_rs),
    .acq_en(acq_en), .clear_req(clear_req), .busy(m_busy), .host_addr(host_addr),
    .host_rd(host_rd), .host_data(m_hd), .host_valid(m_hv), .event_count(m_ev),
    .under_count(m_un), .over_count(m_ov), .dbg_state(m_st));

  peak_histogram #(.BIN_SHIFT(10)) u_ovf (
    .clk(clk), .rst(rst), .peak_in(peak_in), .valid_in(valid_in), .read_shift(o_rs),
    .acq_en(acq_en), .clear_req(clear_req), .busy(o_busy), .host_addr(host_addr),
    .host_rd(host_rd), .host_data(o_hd), .host_valid(o_hv), .event_count(o_ev),
    .under_count(o_un), .over_count(o_ov), .dbg_state(o_st));

  peak_histogram #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .peak_in(peak_in), .valid_in(valid_in), .read_shift(s_rs),
    .acq_en(acq_en), .clear_req(clear_req), .busy(s_busy), .host_addr(host_addr),
    .host_rd(host_rd), .host_data(s_hd), .host_valid(s_hv), .event_count(s_ev),
    .under_count(s_un), .over_count(s_ov), .dbg_state(s_st));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // spec-level model: index 0 = default, 1 = BIN_SHIFT 10, 2 = CNT_W 4
  logic [31:0] mdl_mem [3][1024];
  logic [31:0] mdl_ev [3];
  logic [31:0] mdl_un [3];
  logic [31:0] mdl_ov [3];
  int          mdl_shift [3] = '{13, 10, 13};
  int          mdl_w     [3] = '{32, 32, 4};

  function automatic logic [31:0] mdl_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == top) ? v : v + 32'd1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 1024; a++) mdl_mem[k][a] = '0;
      mdl_ev[k] = '0; mdl_un[k] = '0; mdl_ov[k] = '0;
    end
  endtask

  task automatic model_peak(input peak_t p);
    int sh, b;
    for (int k = 0; k < 3; k++) begin
      if (p < 0) begin
        mdl_un[k] = mdl_inc(mdl_un[k], mdl_w[k]);
      end else begin
        sh = int'(p) >>> mdl_shift[k];
        b  = sh;
        if (sh > 1023) begin
          b = 1023;
          mdl_ov[k] = mdl_inc(mdl_ov[k], mdl_w[k]);
        end
        mdl_mem[k][b] = mdl_inc(mdl_mem[k][b], mdl_w[k]);
        mdl_ev[k] = mdl_inc(mdl_ev[k], mdl_w[k]);
      end
    end
  endtask

  // scoreboard for host reads
  logic [31:0] exp_q[$];
  int          sel_q[$];

  always @(negedge clk) begin
    logic [31:0] e, d;
    int s;
    if (m_hv === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("host_valid_spurious", 32'(m_hv), 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        d = (s == 0) ? m_hd : (s == 1) ? o_hd : {28'd0, s_hd};
        check($sformatf("host_data[%0d]", s), d, e);
      end
    end
  end

  // driver tasks
  task automatic host_read(input int sel, input int addr);
    host_addr = 10'(addr);
    host_rd   = 1'b1;
    exp_q.push_back(mdl_mem[sel][addr]);
    sel_q.push_back(sel);
    @(negedge clk);
    host_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("host_read_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_rs !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("wait_idle_timeout", 32'(m_rs), 32'd1);
  endtask

  task automatic send_peak(input peak_t p);
    wait_idle();
    peak_in  = p;
    valid_in = 1'b1;
    if (acq_en) model_peak(p);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (m_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic clear_hist();
    int n;
    wait_idle();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    model_clear();
    count_busy(n);
    check("clear_busy_cycles", 32'(n), 32'd1024);
  endtask

  initial begin
    int n, lows;
    rst = 1'b1; peak_in = '0; valid_in = 1'b0; acq_en = 1'b1;
    clear_req = 1'b0; host_rd = 1'b0; host_addr = '0;
    model_clear();

    // 1: reset state, init sweep, blank bins
    repeat (1030) @(negedge clk);
    check("rst_busy", 32'(m_busy), 32'd1);
    check("rst_read_shift", 32'(m_rs), 32'd0);
    check("rst_event", m_ev, 32'd0);
    check("rst_under", m_un, 32'd0);
    check("rst_over", m_ov, 32'd0);
    check("rst_host_valid", 32'(m_hv), 32'd0);
    check("rst_host_data", m_hd, 32'd0);
    rst = 1'b0;
    count_busy(n);
    check("init_busy_cycles", 32'(n), 32'd1024);
    check("init_read_shift", 32'(m_rs), 32'd1);
    host_read(0, 0);
    host_read(0, 511);
    host_read(0, 1023);

    // 6a: acquisition disabled
    acq_en = 1'b0; valid_in = 1'b1; peak_in = 24'sh004000;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_rs !== 1'b1) lows++;
    end
    valid_in = 1'b0; acq_en = 1'b1;
    check("acq_off_rs_low_cycles", 32'(lows), 32'd0);
    check("acq_off_event", m_ev, 32'd0);
    check("acq_off_under", m_un, 32'd0);
    host_read(0, 2);

    // 2: single peak latency
    send_peak(24'sh004000);
    check("lat_t1_rs", 32'(m_rs), 32'd0);
    @(negedge clk);
    check("lat_t2_rs", 32'(m_rs), 32'd0);
    @(negedge clk);
    check("lat_t3_rs", 32'(m_rs), 32'd1);
    host_read(0, 2);
    check("hold_host_data", m_hd, mdl_mem[0][2]);
    check("single_event", m_ev, mdl_ev[0]);
    host_read(1, 16);

    // 3 and 4: top of range, bin 1, negative
    clear_hist();
    send_peak(24'sh7FFFFF);
    send_peak(24'sh002000);
    send_peak(-24'sd5);
    wait_idle();
    host_read(0, 1023);
    host_read(0, 1);
    check("mix_under", m_un, mdl_un[0]);
    check("mix_event", m_ev, mdl_ev[0]);
    check("mix_over", m_ov, mdl_ov[0]);
    host_read(1, 1023);
    host_read(1, 8);
    check("ovf_over", o_ov, mdl_ov[1]);
    check("ovf_under", o_un, mdl_un[1]);

    // 5: clear requested during READ
    send_peak(24'sh006000);
    clear_req = 1'b1;
    check("pend_state_read", 32'(m_st), 32'(ST_READ));
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    check("pend_busy", 32'(m_busy), 32'd1);
    check("pend_event", m_ev, mdl_ev[0]);
    host_read(0, 3);
    model_clear();
    count_busy(n);
    check("pend_busy_rest", 32'(n), 32'd1021);
    host_read(0, 3);
    check("pend_event_cleared", m_ev, 32'd0);
    check("pend_under_cleared", m_un, 32'd0);

    // 6b: saturation on the narrow build
    for (int i = 0; i < 20; i++) send_peak(24'sh000100);
    wait_idle();
    host_read(2, 0);
    check("sat_event", 32'(s_ev), mdl_ev[2]);
    host_read(0, 0);
    check("main_event_20", m_ev, mdl_ev[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_histogram.md
Name: peak_histogram

Overview:
- Consumer end of the peak detector's two-stage peak shift register.
- Drives `read_shift`, takes each valid peak and bins it into an on-chip pulse-height histogram (multichannel analyser).
- Host side gets a clear command and a read-only bin port.
- Sits downstream of the trapezoidal filter and peak detector in the DPP chain.

Parameters:
- WD, 23, peak word width minus one (peak words are signed [WD:0]).
- BIN_BITS, 10, log2 of bin count; NBINS = 2^BIN_BITS.
- BIN_SHIFT, 13, right shift applied to a peak to form its bin index.
- CNT_W, 32, width of each bin counter and of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- peak_in  in  WD+1 signed  peak word from the detector's output stage.
- valid_in  in  1  qualifies peak_in.
- read_shift  out  1  shift request to the detector; high only in IDLE.
- acq_en  in  1  when 0, valid peaks are shifted out and discarded uncounted.
- clear_req  in  1  one-cycle pulse requesting a histogram clear.
- busy  out  1  high during CLEAR.
- host_addr  in  BIN_BITS  host read address.
- host_rd  in  1  host read strobe.
- host_data  out  CNT_W  bin contents, valid 1 cycle after host_rd.
- host_valid  out  1  pulses 1 cycle after host_rd.
- event_count  out  CNT_W  peaks binned.
- under_count  out  CNT_W  negative peaks rejected.
- over_count  out  CNT_W  peaks clamped into the top bin.

Behaviour:
- Memory: NBINS x CNT_W, two ports.
  - Port A: FSM read/write.
  - Port B: host read-only, synchronous.
  - Same-address host read during a port-A write returns the old value.
- States: CLEAR, IDLE, READ, UPDATE.
- read_shift = (state == IDLE), a combinational decode of a registered state.
- Reset:
  - state = CLEAR, sweep address 0.
  - event/under/over counts = 0; host_valid = 0; host_data = 0.
  - busy = 1; read_shift = 0.
- CLEAR:
  - Writes 0 to bin addr, addr++ each cycle; NBINS cycles total.
  - After the write to NBINS-1, goes to IDLE and zeroes all three counts in the same edge.
  - clear_req during CLEAR is ignored.
  - Peaks are not accepted (read_shift = 0).
- IDLE, in priority order:
  - clear_req=1 -> CLEAR at addr 0. Any valid_in that cycle is shifted out and discarded.
  - Else valid_in=1, acq_en=1, peak_in<0 -> under_count++, stay IDLE.
  - Else valid_in=1 and acq_en=1 -> latch bin, go to READ.
    - bin = peak_in >>> BIN_SHIFT.
    - If bin > NBINS-1: bin = NBINS-1 and over_count++.
    - With default parameters the clamp is unreachable; the over path is tested with BIN_SHIFT=10.
  - valid_in=0 or acq_en=0 -> stay IDLE, nothing counted.
- READ: port-A read of the latched bin -> UPDATE.
- UPDATE:
  - Writes rdata+1, saturating at 2^CNT_W-1 (a saturated bin holds its value).
  - event_count++ (saturating) -> IDLE.
- Latency: accept at cycle T; read_shift=0 at T+1 and T+2; bin updated at the T+2 edge; read_shift=1 at T+3. Sustained rate is one peak per 3 cycles.
- clear_req during READ/UPDATE is latched as pending. UPDATE completes, then the FSM goes to CLEAR instead of IDLE.
- Statistics counters saturate at all-ones.
- Host port:
  - Operates in every state; host_data = mem[host_addr] registered on host_rd.
  - host_data holds its value when host_rd = 0.
  - During CLEAR it returns possibly-stale data; the host gates reads on busy = 0.
- Reset mid-operation (any state) abandons any in-flight update and re-enters CLEAR.

Decomposition:
- Shared package dpp_pkg:
  - WD and the peak word type.
  - State encoding for CLEAR/IDLE/READ/UPDATE.
  - A saturating-increment function reused by the bin write and the three counters.
- Sub-module hist_ram: a simple dual-port synchronous RAM, port A read/write and port B read, inferred as block RAM.
- The FSM and counters stay in peak_histogram.

Test Plan:
1. Reset, hold 1030 cycles -> busy=1 for exactly 1024 cycles, then read_shift=1; host reads of bins 0, 511, 1023 return 0.
2. Single valid peak 0x004000 (bin 2) at T -> read_shift low at T+1 and T+2, high at T+3; bin 2 = 1; event_count = 1.
3. Peaks 0x7FFFFF, 0x002000, -5 back-to-back, each offered while read_shift=1 -> bin 1023 = 1, bin 1 = 1, under_count = 1, event_count = 2, over_count = 0.
4. BIN_SHIFT=10, peak 0x7FFFFF -> bin 1023 = 1, over_count = 1.
5. clear_req asserted in the READ cycle of a peak to bin 3 -> bin 3 written to 1, then CLEAR runs 1024 cycles and ends with bin 3 = 0 and event_count = 0.
6. acq_en=0 with 10 valid peaks -> read_shift stays 1, all counts and bins stay 0. Then, with acq_en=1, a CNT_W=4 build with 20 peaks to bin 0 -> bin 0 = 15 and event_count = 15.
